// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU-class decode and issue stage toward execute.
// Decodes one instruction per cycle into ALUop plus operands. Results
// pass through a two-entry buffer (output register plus skid register),
// so in_ready is a registered signal and throughput stays at one per cycle.
// Optional macro ALU_ISSUE_PERF_EN adds perf_issued / perf_stall counters.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_aluop,
  output logic [XLEN-1:0] out_ina,
  output logic [XLEN-1:0] out_inb,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_branch,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      aluop;
    logic [XLEN-1:0] ina;
    logic [XLEN-1:0] inb;
    logic [4:0]      rd;
    logic            reg_write;
    logic            branch;
    logic [2:0]      funct3;
    logic            illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{aluop: OP_ADD, default: '0};

  // Shared funct3 -> ALUop map for register and immediate forms; alt selects sub/sra.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = alt ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  // funct7 is legal when zero, or the alternate encoding on add/sub and shift-right slots.
  function automatic logic f7_ok(input logic [6:0] f7, input logic [2:0] f3, input logic imm_form);
    logic alt_slot;
    alt_slot = imm_form ? (f3 == 3'b101) : (f3 == 3'b000 || f3 == 3'b101);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && alt_slot);
  endfunction

  // Full decode of one instruction; illegal encodings collapse to a harmless add of zeros.
  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
    entry_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    f3    = instr[14:12];
    f7    = instr[31:25];
    imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    imm_u = {instr[31:12], 12'b0};
    e = RESET_ENTRY;
    e.funct3 = f3;
    case (instr[6:0])
      OPC_R: begin
        if (f7_ok(f7, f3, 1'b0)) begin
          e.aluop     = alu_from_f3(f3, f7[5]);
          e.ina       = rs1;
          e.inb       = (f3 == 3'b001 || f3 == 3'b101) ? {{(XLEN-5){1'b0}}, rs2[4:0]} : rs2;
          e.reg_write = 1'b1;
        end else begin
          e.illegal = 1'b1;
        end
      end
      OPC_I: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (f7_ok(f7, f3, 1'b1)) begin
            e.aluop     = alu_from_f3(f3, f7[5]);
            e.ina       = rs1;
            e.inb       = {{(XLEN-5){1'b0}}, instr[24:20]};
            e.reg_write = 1'b1;
          end else begin
            e.illegal = 1'b1;
          end
        end else begin
          e.aluop     = alu_from_f3(f3, 1'b0);
          e.ina       = rs1;
          e.inb       = imm_i;
          e.reg_write = 1'b1;
        end
      end
      OPC_LUI: begin
        e.inb       = imm_u;
        e.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        e.ina       = pc;
        e.inb       = imm_u;
        e.reg_write = 1'b1;
      end
      OPC_BR: begin
        case (f3)
          3'b000, 3'b001: e.aluop = OP_SUB;
          3'b100, 3'b101: e.aluop = OP_SLT;
          3'b110, 3'b111: e.aluop = OP_SLTU;
          default:        e.illegal = 1'b1;
        endcase
        if (!e.illegal) begin
          e.ina    = rs1;
          e.inb    = rs2;
          e.branch = 1'b1;
        end
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) begin
      e.aluop     = OP_ADD;
      e.ina       = '0;
      e.inb       = '0;
      e.reg_write = 1'b0;
      e.branch    = 1'b0;
    end
    e.rd = e.reg_write ? instr[11:7] : 5'd0;
    return e;
  endfunction

  entry_t dec_p0;
  entry_t out_p1;
  entry_t skid_p1;
  logic   out_vld_p1;
  logic   skid_full;

  // Stage 0: combinational decode of the presented instruction.
  always_comb begin
    dec_p0 = decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
  end

  assign in_ready = !skid_full;

  // Stage 1: output register with skid; the skid entry always drains first to keep order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_vld_p1 <= 1'b0;
      skid_full  <= 1'b0;
      out_p1     <= RESET_ENTRY;
      skid_p1    <= RESET_ENTRY;
    end else if (!out_vld_p1 || out_ready) begin
      if (skid_full) begin
        out_p1     <= skid_p1;
        out_vld_p1 <= 1'b1;
        skid_full  <= 1'b0;
      end else if (in_valid) begin
        out_p1     <= dec_p0;
        out_vld_p1 <= 1'b1;
      end else begin
        out_vld_p1 <= 1'b0;
      end
    end else if (in_valid && !skid_full) begin
      skid_p1   <= dec_p0;
      skid_full <= 1'b1;
    end
  end

  assign out_valid     = out_vld_p1;
  assign out_aluop     = out_p1.aluop;
  assign out_ina       = out_p1.ina;
  assign out_inb       = out_p1.inb;
  assign out_rd        = out_p1.rd;
  assign out_reg_write = out_p1.reg_write;
  assign out_branch    = out_p1.branch;
  assign out_funct3    = out_p1.funct3;
  assign out_illegal   = out_p1.illegal;

`ifdef ALU_ISSUE_PERF_EN
  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (out_vld_p1 && out_ready) perf_issued <= perf_issued + 32'd1;
      if (in_valid && skid_full)   perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed cases plus a randomized stream.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic [3:0]  out_aluop;
  logic [31:0] out_ina, out_inb;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_branch, out_illegal;
  logic [2:0]  out_funct3;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
  int unsigned tb_issued = 0, tb_stall = 0;
`endif

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_ina(out_ina), .out_inb(out_inb), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_branch(out_branch),
    .out_funct3(out_funct3), .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] ina;
    logic [31:0] inb;
    logic [4:0]  rd;
    logic        reg_write;
    logic        branch;
    logic [2:0]  funct3;
    logic        illegal;
  } exp_t;

  localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_SLT = 4'b1000;
  localparam logic [3:0] A_SLTU = 4'b0111, A_SRA = 4'b1001;
  // Mnemonic table indexed by funct3: add sll slt sltu xor srl or and
  localparam logic [3:0] F3_OP [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0111,
                                       4'b0011, 4'b0101, 4'b0001, 4'b0000};

  int   n_checks = 0, n_fail = 0, delivered = 0;
  exp_t q[$];
  exp_t obs, prev_obs;
  logic hold_prev = 1'b0, cleared = 1'b0;

  assign obs = {out_aluop, out_ina, out_inb, out_rd, out_reg_write, out_branch, out_funct3, out_illegal};

  // Reference: meaning of each instruction written from the ISA rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7, op;
    logic signed [11:0] imm12;
    logic legal, shift;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; imm12 = ins[31:20];
    shift = (f3 == 3'd1 || f3 == 3'd5);
    e = '0; e.aluop = A_ADD; e.funct3 = f3; legal = 1'b0;
    if (op == 7'h33) begin
      if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        legal = 1'b1; e.reg_write = 1'b1; e.ina = a;
        e.inb = shift ? (b % 32) : b;
        e.aluop = (f7 == 7'h20) ? ((f3 == 3'd0) ? A_SUB : A_SRA) : F3_OP[f3];
      end
    end else if (op == 7'h13) begin
      if (!shift) begin
        legal = 1'b1; e.reg_write = 1'b1; e.ina = a;
        e.inb = 32'(int'(imm12)); e.aluop = F3_OP[f3];
      end else if (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)) begin
        legal = 1'b1; e.reg_write = 1'b1; e.ina = a;
        e.inb = 32'(ins[24:20]);
        e.aluop = (f7 == 7'h20) ? A_SRA : F3_OP[f3];
      end
    end else if (op == 7'h37 || op == 7'h17) begin
      legal = 1'b1; e.reg_write = 1'b1;
      e.ina = (op == 7'h17) ? pc : 32'd0;
      e.inb = ins & 32'hFFFF_F000;
    end else if (op == 7'h63) begin
      if (f3 != 3'd2 && f3 != 3'd3) begin
        legal = 1'b1; e.branch = 1'b1; e.ina = a; e.inb = b;
        e.aluop = (f3 < 3'd2) ? A_SUB : ((f3 < 3'd6) ? A_SLT : A_SLTU);
      end
    end
    e.illegal = !legal;
    e.rd = e.reg_write ? ins[11:7] : 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 4);
    r[31:25] = (k < 3) ? 7'h00 : ((k == 3) ? 7'h20 : 7'($urandom));
    case ($urandom_range(0, 9))
      0, 1, 2: r[6:0] = 7'h33;
      3, 4:    r[6:0] = 7'h13;
      5:       r[6:0] = 7'h37;
      6:       r[6:0] = 7'h17;
      7, 8:    r[6:0] = 7'h63;
      default: r[6:0] = 7'($urandom);
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard producer: record every accepted input at the edge it is taken.
  always @(posedge clk) begin
    cleared <= rst || flush;
    if (rst || flush) q.delete();
    else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
`ifdef ALU_ISSUE_PERF_EN
    if (rst) begin
      tb_issued = 0; tb_stall = 0;
    end else begin
      if (out_valid && out_ready) tb_issued++;
      if (in_valid && !in_ready) tb_stall++;
    end
`endif
  end

  // Monitor: compare each output handshake against the scoreboard; held outputs must not move.
  always @(negedge clk) begin
    if (hold_prev && !cleared)
      chk("hold_stable", 128'({out_valid, obs}), 128'({1'b1, prev_obs}));
    if (out_valid && out_ready) begin
      delivered++;
      if (q.size() == 0) chk("unexpected_output", 128'(obs), 128'(0) - 128'(1));
      else chk("scoreboard", 128'(obs), 128'(q.pop_front()));
    end
    hold_prev = out_valid && !out_ready;
    prev_obs  = obs;
  end

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    logic took;
    in_instr = i; in_pc = p; in_rs1_data = a; in_rs2_data = b; in_valid = 1'b1;
    took = 1'b0;
    for (int k = 0; k < 100 && !took; k++) begin
      took = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!took) chk("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 100 && (q.size() != 0 || out_valid); k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    chk("drain_empty", 128'(q.size()), 128'(0));
  endtask

  localparam exp_t RST_VAL = '{aluop: 4'b0010, default: '0};

  initial begin
    int base;
    logic took;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_fields", 128'(obs), 128'(RST_VAL));
    rst = 1'b0; out_ready = 1'b1;

    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("add_latency_valid", 128'(out_valid), 128'(1));
    chk("add_fields", 128'({out_aluop, out_ina, out_inb, out_rd, out_reg_write}),
        128'({4'b0010, 32'd5, 32'd7, 5'd3, 1'b1}));
    send(32'h40435293, 32'h0, 32'h8000_0000, 32'h0);
    chk("srai_op_inb", 128'({out_aluop, out_inb}), 128'({4'b1001, 32'd4}));
    send(32'h003110B3, 32'h0, 32'h1, 32'h0000_0025);
    chk("sll_inb", 128'(out_inb), 128'(32'd5));
    send(32'hFFF00093, 32'h0, 32'h0, 32'h0);
    chk("addi_neg_imm", 128'(out_inb), 128'(32'hFFFF_FFFF));
    send(32'h12345137, 32'h0, 32'hDEAD_BEEF, 32'h0);
    chk("lui_ops", 128'({out_ina, out_inb}), 128'({32'd0, 32'h1234_5000}));
    send(32'h00001197, 32'h100, 32'h0, 32'h0);
    chk("auipc_ina", 128'({out_ina, out_inb}), 128'({32'h100, 32'h1000}));
    send(32'h0020E063, 32'h0, 32'h11, 32'h22);
    chk("bltu_ctrl", 128'({out_aluop, out_branch, out_reg_write, out_rd}),
        128'({4'b0111, 1'b1, 1'b0, 5'd0}));
    send(32'h0000_0FFF, 32'h0, 32'h3, 32'h4);
    chk("illegal_opc", 128'({out_illegal, out_aluop, out_rd, out_ina}),
        128'({1'b1, 4'b0010, 5'd0, 32'd0}));
    drain();

    // Four back-to-back with execute stalled: only two fit.
    base = delivered;
    out_ready = 1'b0;
    send(32'h00A00533, 32'h0, 32'd1, 32'd2);
    chk("b2b_ready_after1", 128'(in_ready), 128'(1));
    send(32'h40B50633, 32'h0, 32'd3, 32'd4);
    chk("b2b_ready_after2", 128'(in_ready), 128'(0));
    in_instr = 32'h00C5F6B3; in_rs1_data = 32'd5; in_rs2_data = 32'd6; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_full_ready", 128'({in_ready, out_valid}), 128'({1'b0, 1'b1}));
    out_ready = 1'b1;
    send(32'h00C5F6B3, 32'h0, 32'd5, 32'd6);
    send(32'h00D6E733, 32'h0, 32'd7, 32'd8);
    drain();
    chk("b2b_delivered", 128'(delivered - base), 128'(4));

    // Flush while full with a new input presented.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd9, 32'd9);
    send(32'h002081B3, 32'h0, 32'd8, 32'd8);
    in_instr = 32'h00310233; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_state", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_no_ghost", 128'(out_valid), 128'(0));
    send(32'h00F00793, 32'h0, 32'd1, 32'd0);
    drain();

    // Same scenario with rst.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd9, 32'd9);
    send(32'h002081B3, 32'h0, 32'd8, 32'd8);
    in_instr = 32'h00310233; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_state", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
    chk("rst_fields", 128'(obs), 128'(RST_VAL));

    // Randomized stream with random execute back-pressure.
    for (int c = 0; c < 600; c++) begin
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_instr = rand_instr(); in_pc = $urandom;
        in_rs1_data = $urandom; in_rs2_data = $urandom; in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) in_valid = 1'b0;
    end
    drain();

`ifdef ALU_ISSUE_PERF_EN
    chk("perf_issued", 128'(perf_issued), 128'(tb_issued));
    chk("perf_stall", 128'(perf_stall), 128'(tb_stall));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage that feeds the ALU: decodes RV32I ALU-class instructions into the 4-bit ALUop plus operand pair (ina, inb), and registers them toward execute.
- Ready/valid on both sides with a 2-entry buffer (output register + skid register), giving full throughput with a registered in_ready.
- Sits between register-file read and the ALU. Execute consumes out_* when out_valid && out_ready.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all buffered entries and any input presented this cycle
- in_valid  in  1  instruction + operands valid
- in_ready  out  1  stage can accept; registered, equals !skid_full
- in_instr  in  32  raw instruction word
- in_pc  in  32  instruction address
- in_rs1_data  in  32  rs1 register value
- in_rs2_data  in  32  rs2 register value
- out_valid  out  1  decoded entry valid
- out_ready  in  1  execute accepts entry
- out_aluop  out  4  ALU operation code
- out_ina  out  32  ALU operand A
- out_inb  out  32  ALU operand B
- out_rd  out  5  destination register
- out_reg_write  out  1  result is written back
- out_branch  out  1  conditional branch compare; out_funct3 selects condition
- out_funct3  out  3  instr[14:12] passthrough
- out_illegal  out  1  unsupported opcode/encoding

Behaviour:
- ALUop encoding:
  - add 0010, sub 0110, and 0000, or 0001, xor 0011
  - sll 0100, srl 0101, sra 1001
  - slt 1000, sltu 0111
- Decode, opcode 0110011 (R-type): funct3/funct7 map to add/sub/sll/slt/sltu/xor/srl/sra/or/and.
  - funct7 must be 0000000, or 0100000 for sub/sra only; otherwise illegal.
  - ina=rs1, inb=rs2. Shifts use inb={27'b0, rs2[4:0]}.
- Decode, opcode 0010011 (I-type ALU): ina=rs1, inb=sign-extended imm[11:0].
  - slli/srli/srai: inb={27'b0, instr[24:20]}. instr[31:25] must be 0000000, or 0100000 for srai only; otherwise illegal.
- Decode, 0110111 (LUI): ALUop add, ina=0, inb={instr[31:12], 12'b0}.
- Decode, 0010111 (AUIPC): ALUop add, ina=pc, inb={instr[31:12], 12'b0}.
- Decode, 1100011 (branch): reg_write=0, branch=1, ina=rs1, inb=rs2.
  - funct3 000/001 -> sub; 100/101 -> slt; 110/111 -> sltu; 010/011 -> illegal.
- All other opcodes, and the illegal cases above: illegal=1, ALUop=add, ina=inb=0, reg_write=0, branch=0. The entry is still issued.
- reg_write=1 for R-type, I-type, LUI, AUIPC. rd=instr[11:7], forced to 0 when reg_write=0.
- Reset: out_valid=0, skid_full=0, in_ready=1. All out_* data fields are 0 (out_aluop=0010).
- Latency: an input accepted at edge N with an empty output register appears with out_valid=1 after edge N.
- Buffering:
  - Output register loads when it is empty or being consumed.
  - If the output register is full and not consumed, the accepted input goes to the skid register. in_ready drops the next cycle.
  - When the output register is consumed, the skid entry moves into it and skid_full clears.
  - Order is strictly preserved.
- Simultaneous accept+consume with skid empty: the output register takes the new entry; out_valid stays 1.
- Full (both entries held, out_ready=0): in_ready=0 and the input is ignored. out_* stay stable while out_valid && !out_ready.
- flush: next cycle out_valid=0, skid_full=0, in_ready=1. An input handshaking in the flush cycle is discarded. flush and rst are equivalent except flush does not clear the perf counters.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- When defined, adds two 32-bit output ports:
  - perf_issued: increments on each out handshake.
  - perf_stall: increments each cycle with in_valid && !in_ready.
  - Both wrap at 2^32. rst clears both.
- When undefined, the ports and counters are absent, with no functional change otherwise.

Test Plan:
- add x3,x1,x2 (0x002081B3) with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, aluop=0010, ina=5, inb=7, rd=3, reg_write=1.
- srai x5,x6,4 (0x40435293) with rs1=0x80000000 -> aluop=1001, inb=4. sll with rs2=0x00000025 -> inb=5.
- addi x1,x0,-1 (0xFFF00093) -> inb=0xFFFFFFFF. lui x2,0x12345 -> ina=0, inb=0x12345000. auipc at pc=0x100 -> ina=0x100.
- bltu (funct3 110) -> aluop=0111, branch=1, reg_write=0, rd=0. Opcode 0x7F -> illegal=1, aluop=0010.
- Back-to-back stream of 4 instructions with out_ready held 0 -> 2 accepted, in_ready=0 from the 3rd cycle. Release out_ready -> all 4 delivered in order, none dropped or duplicated.
- Full buffer plus flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears. Same scenario with rst -> all outputs at reset values.
